// File: rtl/spi_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_mem_slave: SPI mode-0 slave with READ/WRITE/ID over a byte RAM.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_mem_slave #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] ID_BYTE   = 8'hA5,
  parameter             INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_sck,
  input  logic       spi_cs,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       busy,
  output logic [7:0] last_cmd,
  output logic       xfer_done
);

  localparam int         c_DEPTH     = 1 << ADDR_W;
  localparam logic [7:0] c_CMD_READ  = 8'h03;
  localparam logic [7:0] c_CMD_WRITE = 8'h02;
  localparam logic [7:0] c_CMD_ID    = 8'h9F;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_RD     = 3'd3,
    S_WR     = 3'd4,
    S_ID     = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_sck_m, r_sck_s, r_sck_d;
  logic              r_cs_m, r_cs_s;
  logic              r_mosi_m, r_mosi_s;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_rx_sr;
  logic [6:0]        r_tx_sr;
  logic              r_miso;
  logic              r_load_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_last_cmd;
  logic              r_xfer_done;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_mem [c_DEPTH];

  logic       w_rise, w_fall, w_active, w_byte_done, w_mem_we;
  logic [7:0] w_rx_byte, w_tx_src;

  assign w_rise      = r_sck_s & ~r_sck_d;
  assign w_fall      = ~r_sck_s & r_sck_d;
  assign w_active    = ~r_cs_s & (r_state != S_IDLE);
  assign w_byte_done = w_active & w_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_sr, r_mosi_s};
  assign w_mem_we    = w_byte_done & (r_state == S_WR);
  assign w_tx_src    = (r_state == S_ID) ? ID_BYTE : r_rd_data;

  assign spi_miso  = r_miso;
  assign busy      = ~r_cs_s;
  assign last_cmd  = r_last_cmd;
  assign xfer_done = r_xfer_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_m  <= 1'b0;
      r_sck_s  <= 1'b0;
      r_sck_d  <= 1'b0;
      r_cs_m   <= 1'b1;
      r_cs_s   <= 1'b1;
      r_mosi_m <= 1'b0;
      r_mosi_s <= 1'b0;
    end else begin
      r_sck_m  <= spi_sck;
      r_sck_s  <= r_sck_m;
      r_sck_d  <= r_sck_s;
      r_cs_m   <= spi_cs;
      r_cs_s   <= r_cs_m;
      r_mosi_m <= spi_mosi;
      r_mosi_s <= r_mosi_m;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_cs_s) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_byte_done) begin
            case (w_rx_byte)
              c_CMD_READ, c_CMD_WRITE: w_state_nxt = S_ADDR;
              c_CMD_ID:                w_state_nxt = S_ID;
              default:                 w_state_nxt = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (w_byte_done)
            w_state_nxt = (r_last_cmd == c_CMD_READ) ? S_RD : S_WR;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // A reload is armed on byte completion and consumed on the following fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt   <= 3'd0;
      r_rx_sr     <= 7'd0;
      r_tx_sr     <= 7'd0;
      r_miso      <= 1'b0;
      r_load_pend <= 1'b0;
      r_addr      <= '0;
      r_last_cmd  <= 8'h00;
      r_xfer_done <= 1'b0;
    end else begin
      r_xfer_done <= r_cs_s & (r_state != S_IDLE);
      if (!w_active) begin
        r_bit_cnt   <= 3'd0;
        r_tx_sr     <= 7'd0;
        r_miso      <= 1'b0;
        r_load_pend <= 1'b0;
      end else begin
        if (w_rise) begin
          r_rx_sr   <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            case (r_state)
              S_CMD: begin
                r_last_cmd  <= w_rx_byte;
                r_load_pend <= (w_rx_byte == c_CMD_ID);
              end
              S_ADDR: begin
                r_addr      <= ADDR_W'(w_rx_byte);
                r_load_pend <= (r_last_cmd == c_CMD_READ);
              end
              S_RD, S_ID: r_load_pend <= 1'b1;
              S_WR:       r_addr <= r_addr + ADDR_W'(1);
              default: ;
            endcase
          end
        end
        if (w_fall) begin
          if (r_state == S_RD || r_state == S_ID) begin
            if (r_load_pend) begin
              r_tx_sr     <= w_tx_src[6:0];
              r_miso      <= w_tx_src[7];
              r_load_pend <= 1'b0;
              if (r_state == S_RD) r_addr <= r_addr + ADDR_W'(1);
            end else begin
              r_tx_sr <= {r_tx_sr[5:0], 1'b0};
              r_miso  <= r_tx_sr[6];
            end
          end else begin
            r_miso <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= w_rx_byte;
    else          r_rd_data     <= r_mem[r_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_mem_slave: randomized SPI master against a byte-array model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spi_mem_slave;

  localparam int         HALF   = 6;
  localparam logic [7:0] ID_VAL = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, busy, xfer_done;
  logic [7:0] last_cmd;

  int n_cmp = 0;
  int n_err = 0;
  int xd_cnt = 0;

  logic [7:0] ref_mem [256];
  bit         ref_vld [256];
  logic [7:0] ref_last_cmd = 8'h00;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] wdata_q [$];

  spi_mem_slave dut (
    .clk       (clk),
    .resetn    (resetn),
    .spi_sck   (spi_sck),
    .spi_cs    (spi_cs),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .busy      (busy),
    .last_cmd  (last_cmd),
    .xfer_done (xfer_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (xfer_done === 1'b1) xd_cnt <= xd_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      wait_clk(HALF);
      spi_sck = 1'b1;
      rx[i]   = spi_miso;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_xact();
    logic [7:0] r;
    rx_q.delete();
    cs_low();
    foreach (tx_q[i]) begin
      spi_bits(tx_q[i], 8, r);
      rx_q.push_back(r);
    end
    cs_high();
  endtask

  task automatic do_write(input logic [7:0] a);
    tx_q = {8'h02, a};
    foreach (wdata_q[k]) begin
      tx_q.push_back(wdata_q[k]);
      ref_mem[8'(a + k)] = wdata_q[k];
      ref_vld[8'(a + k)] = 1'b1;
    end
    ref_last_cmd = 8'h02;
    run_xact();
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    tx_q = {8'h03, a};
    for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
    ref_last_cmd = 8'h03;
    run_xact();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wait_clk(3);
    n_cmp++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (last_cmd !== 8'h00) begin n_err++; $display("FAIL reset_last_cmd: got %h want 00", last_cmd); end
    n_cmp++; if (xfer_done !== 1'b0) begin n_err++; $display("FAIL reset_xfer_done: got %b want 0", xfer_done); end
    resetn = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_id();
    logic [7:0] r;
    int x0;
    x0 = xd_cnt;
    cs_low();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL id_busy: got %b want 1", busy); end
    spi_bits(8'h9F, 8, r);
    n_cmp++; if (r !== 8'h00) begin n_err++; $display("FAIL id_cmd_miso: got %h want 00", r); end
    for (int k = 0; k < 2; k++) begin
      spi_bits(8'($urandom), 8, r);
      n_cmp++; if (r !== ID_VAL) begin n_err++; $display("FAIL id_byte%0d: got %h want %h", k, r, ID_VAL); end
    end
    cs_high();
    ref_last_cmd = 8'h9F;
    n_cmp++; if (last_cmd !== ref_last_cmd) begin n_err++; $display("FAIL id_last_cmd: got %h want %h", last_cmd, ref_last_cmd); end
    n_cmp++; if (xd_cnt - x0 != 1) begin n_err++; $display("FAIL id_xfer_done: got %0d pulses want 1", xd_cnt - x0); end
    n_cmp++; if (busy !== 1'b0 || spi_miso !== 1'b0) begin n_err++; $display("FAIL id_idle: got busy=%b miso=%b want 0/0", busy, spi_miso); end
  endtask

  task automatic test_write_read();
    wdata_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_write(8'h10);
    do_read(8'h10, 4);
    n_cmp++; if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'h00) begin n_err++; $display("FAIL wr_rd_hdr_miso: got %h %h want 00 00", rx_q[0], rx_q[1]); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rx_q[2+k] !== ref_mem[8'(8'h10 + k)]) begin n_err++; $display("FAIL wr_rd_byte%0d: got %h want %h", k, rx_q[2+k], ref_mem[8'(8'h10 + k)]); end
    end
    n_cmp++; if (last_cmd !== 8'h03) begin n_err++; $display("FAIL wr_rd_last_cmd: got %h want 03", last_cmd); end
  endtask

  task automatic test_wrap();
    wdata_q = {8'h11, 8'h22};
    do_write(8'hFF);
    do_read(8'hFF, 2);
    n_cmp++; if (rx_q[2] !== 8'h11) begin n_err++; $display("FAIL wrap_ff: got %h want 11", rx_q[2]); end
    n_cmp++; if (rx_q[3] !== 8'h22) begin n_err++; $display("FAIL wrap_00: got %h want 22", rx_q[3]); end
    do_read(8'h00, 1);
    n_cmp++; if (rx_q[2] !== 8'h22) begin n_err++; $display("FAIL wrap_mem00: got %h want 22", rx_q[2]); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    wdata_q = {8'($urandom)};
    do_write(8'h21);
    cs_low();
    spi_bits(8'h02, 8, r);
    spi_bits(8'h20, 8, r);
    spi_bits(8'h55, 8, r);
    spi_bits(8'($urandom), 4, r);
    cs_high();
    ref_mem[8'h20] = 8'h55;
    ref_vld[8'h20] = 1'b1;
    do_read(8'h20, 2);
    n_cmp++; if (rx_q[2] !== 8'h55) begin n_err++; $display("FAIL abort_kept: got %h want 55", rx_q[2]); end
    n_cmp++; if (rx_q[3] !== ref_mem[8'h21]) begin n_err++; $display("FAIL abort_discarded: got %h want %h", rx_q[3], ref_mem[8'h21]); end
  endtask

  task automatic test_unknown();
    tx_q = {8'h5A, 8'h10, 8'h02, 8'($urandom)};
    run_xact();
    ref_last_cmd = 8'h5A;
    foreach (rx_q[k]) begin
      n_cmp++; if (rx_q[k] !== 8'h00) begin n_err++; $display("FAIL unknown_miso%0d: got %h want 00", k, rx_q[k]); end
    end
    n_cmp++; if (last_cmd !== 8'h5A) begin n_err++; $display("FAIL unknown_last_cmd: got %h want 5A", last_cmd); end
    do_read(8'h10, 4);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rx_q[2+k] !== ref_mem[8'(8'h10 + k)]) begin n_err++; $display("FAIL unknown_mem%0d: got %h want %h", k, rx_q[2+k], ref_mem[8'(8'h10 + k)]); end
    end
  endtask

  task automatic test_partial_cmd();
    logic [7:0] r;
    int x0;
    x0 = xd_cnt;
    cs_low();
    spi_bits(8'h9F, 5, r);
    cs_high();
    n_cmp++; if (last_cmd !== ref_last_cmd) begin n_err++; $display("FAIL partial_last_cmd: got %h want %h", last_cmd, ref_last_cmd); end
    n_cmp++; if (xd_cnt - x0 != 1) begin n_err++; $display("FAIL partial_xfer_done: got %0d pulses want 1", xd_cnt - x0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    cs_low();
    spi_bits(8'h03, 8, r);
    spi_bits(8'h10, 4, r);
    resetn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (last_cmd !== 8'h00) begin n_err++; $display("FAIL rstmid_last_cmd: got %h want 00", last_cmd); end
    n_cmp++; if (spi_miso !== 1'b0) begin n_err++; $display("FAIL rstmid_miso: got %b want 0", spi_miso); end
    spi_cs = 1'b1;
    wait_clk(4);
    resetn = 1'b1;
    wait_clk(4);
    do_read(8'h10, 2);
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (rx_q[2+k] !== ref_mem[8'(8'h10 + k)]) begin n_err++; $display("FAIL rstmid_read%0d: got %h want %h", k, rx_q[2+k], ref_mem[8'(8'h10 + k)]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    int         n;
    for (int it = 0; it < 8; it++) begin
      a = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      wdata_q.delete();
      for (int k = 0; k < n; k++) wdata_q.push_back(8'($urandom));
      do_write(a);
      do_read(a, n + 1);
      for (int k = 0; k <= n; k++) begin
        if (ref_vld[8'(a + k)]) begin
          n_cmp++;
          if (rx_q[2+k] !== ref_mem[8'(a + k)]) begin
            n_err++;
            $display("FAIL rand_it%0d_a%h_k%0d: got %h want %h", it, a, k, rx_q[2+k], ref_mem[8'(a + k)]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int x0;
    x0 = xd_cnt;
    wdata_q = {8'($urandom), 8'($urandom)};
    do_write(8'h40);
    do_read(8'h40, 2);
    n_cmp++; if (rx_q[2] !== ref_mem[8'h40] || rx_q[3] !== ref_mem[8'h41]) begin
      n_err++; $display("FAIL b2b_data: got %h %h want %h %h", rx_q[2], rx_q[3], ref_mem[8'h40], ref_mem[8'h41]);
    end
    n_cmp++; if (xd_cnt - x0 != 2) begin n_err++; $display("FAIL b2b_xfer_done: got %0d pulses want 2", xd_cnt - x0); end
  endtask

  initial begin
    foreach (ref_vld[i]) ref_vld[i] = 1'b0;
    test_reset();
    test_id();
    test_write_read();
    test_wrap();
    test_abort();
    test_unknown();
    test_partial_cmd();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
